// File: rtl/truth_table_sweeper_pkg.sv
// rtl/truth_table_sweeper_pkg.sv - shared types and constants for the truth-table sweeper
package truth_table_sweeper_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SAMPLE,
        ST_EMIT,
        ST_DONE
    } state_e;

    localparam int DEF_N_IN = 2;

    // Implication ~a|b for vector {a,b}: only vector 2 (a=1,b=0) yields 0
    localparam logic [3:0] IMPL_LUT = 4'b1011;

    function automatic int depth_of(input int n_in);
        return 1 << n_in;
    endfunction

endpackage

// File: rtl/truth_table_sweeper_golden_lut.sv
// rtl/truth_table_sweeper_golden_lut.sv - writable golden truth table with indexed read
module truth_table_sweeper_golden_lut
    import truth_table_sweeper_pkg::*;
#(
    parameter int                              N_IN = DEF_N_IN,
    parameter logic [depth_of(N_IN)-1:0]       INIT = IMPL_LUT
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        we,
    input  logic [depth_of(N_IN)-1:0]   wdata,
    input  logic [N_IN-1:0]             idx,
    output logic                        rdata
);

    logic [depth_of(N_IN)-1:0] table_q;
    logic [depth_of(N_IN)-1:0] table_d;

    // Next table contents: replaced wholesale on a write, otherwise held
    always_comb begin
        table_d = table_q;
        if (we) begin
            table_d = wdata;
        end
    end

    // Table storage, returns to the built-in default on reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            table_q <= INIT;
        end else begin
            table_q <= table_d;
        end
    end

    assign rdata = table_q[idx];

endmodule

// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - exhaustive input sweep of an N-input block against a golden table
module truth_table_sweeper
    import truth_table_sweeper_pkg::*;
#(
    parameter int                           N_IN        = DEF_N_IN,
    parameter int                           SETTLE      = 1,
    parameter logic [depth_of(N_IN)-1:0]    DEFAULT_LUT = IMPL_LUT
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        lut_we,
    input  logic [depth_of(N_IN)-1:0]   lut_data,
    input  logic                        start,
    output logic                        busy,
    output logic [N_IN-1:0]             dut_in,
    input  logic                        dut_out,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [N_IN-1:0]             out_vec,
    output logic                        out_bit,
    output logic                        out_exp,
    output logic                        out_err,
    output logic [N_IN:0]               mismatch_cnt,
    output logic                        done,
    output logic                        pass
);

    localparam int DEPTH = depth_of(N_IN);

    state_e             state_q,     state_d;
    logic [N_IN:0]      vec_q,       vec_d;
    logic [3:0]         settle_q,    settle_d;
    logic [N_IN:0]      mism_q,      mism_d;
    logic               pass_q,      pass_d;
    logic               done_q,      done_d;
    logic               busy_q,      busy_d;
    logic               out_valid_q, out_valid_d;
    logic [N_IN-1:0]    out_vec_q,   out_vec_d;
    logic               out_bit_q,   out_bit_d;
    logic               out_exp_q,   out_exp_d;
    logic               out_err_q,   out_err_d;
    logic               gold_bit;
    logic               lut_load;

    // The table is only writable while idle so a sweep always sees one frozen table
    assign lut_load = lut_we && (state_q == ST_IDLE);

    truth_table_sweeper_golden_lut #(
        .N_IN (N_IN),
        .INIT (DEFAULT_LUT)
    ) u_golden_lut (
        .clk   (clk),
        .reset (reset),
        .we    (lut_load),
        .wdata (lut_data),
        .idx   (vec_q[N_IN-1:0]),
        .rdata (gold_bit)
    );

    // Sweep sequencing: drive, settle, sample, then hand the record to the consumer
    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        settle_d    = settle_q;
        mism_d      = mism_q;
        pass_d      = pass_q;
        done_d      = 1'b0;
        out_valid_d = 1'b0;
        out_vec_d   = out_vec_q;
        out_bit_d   = out_bit_q;
        out_exp_d   = out_exp_q;
        out_err_d   = out_err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_DRIVE;
                    vec_d    = '0;
                    settle_d = '0;
                    mism_d   = '0;
                    pass_d   = 1'b0;
                end
            end
            ST_DRIVE: begin
                if (settle_q == 4'(SETTLE - 1)) begin
                    settle_d = '0;
                    state_d  = ST_SAMPLE;
                end else begin
                    settle_d = settle_q + 4'd1;
                end
            end
            ST_SAMPLE: begin
                out_vec_d   = vec_q[N_IN-1:0];
                out_bit_d   = dut_out;
                out_exp_d   = gold_bit;
                out_err_d   = dut_out ^ gold_bit;
                if (dut_out != gold_bit) begin
                    mism_d = mism_q + (N_IN+1)'(1);
                end
                out_valid_d = 1'b1;
                state_d     = ST_EMIT;
            end
            ST_EMIT: begin
                if (out_ready) begin
                    if (vec_q == (N_IN+1)'(DEPTH - 1)) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        pass_d  = (mism_q == '0);
                    end else begin
                        vec_d   = vec_q + (N_IN+1)'(1);
                        state_d = ST_DRIVE;
                    end
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Sweep state and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            vec_q       <= '0;
            settle_q    <= '0;
            mism_q      <= '0;
            pass_q      <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_vec_q   <= '0;
            out_bit_q   <= 1'b0;
            out_exp_q   <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            settle_q    <= settle_d;
            mism_q      <= mism_d;
            pass_q      <= pass_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_vec_q   <= out_vec_d;
            out_bit_q   <= out_bit_d;
            out_exp_q   <= out_exp_d;
            out_err_q   <= out_err_d;
        end
    end

    assign busy         = busy_q;
    assign dut_in       = vec_q[N_IN-1:0];
    assign out_valid    = out_valid_q;
    assign out_vec      = out_vec_q;
    assign out_bit      = out_bit_q;
    assign out_exp      = out_exp_q;
    assign out_err      = out_err_q;
    assign mismatch_cnt = mism_q;
    assign done         = done_q;
    assign pass         = pass_q;

endmodule
